// File: rtl/bounded_step_counter.sv
// Bounded up/down counter with programmable step, run-time bounds and
// wrap / saturate / bounce boundary modes, plus a terminal-count event counter.
module bounded_step_counter #(
    parameter int unsigned          DATA_WIDTH    = 32,
    parameter int unsigned          STEP_WIDTH    = 8,
    parameter int unsigned          EVT_CNT_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     load,
    input  logic [DATA_WIDTH-1:0]    load_value,
    input  logic [DATA_WIDTH-1:0]    lower_bound,
    input  logic [DATA_WIDTH-1:0]    upper_bound,
    input  logic [STEP_WIDTH-1:0]    step,
    input  logic                     dir,
    input  logic [1:0]               mode,
    output logic [DATA_WIDTH-1:0]    out,
    output logic                     cur_dir,
    output logic                     tc,
    output logic                     bound_err,
    output logic [EVT_CNT_WIDTH-1:0] evt_cnt
);

    localparam int unsigned SUM_W = DATA_WIDTH + 1;

    localparam logic [1:0] MODE_SAT    = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;

    logic [DATA_WIDTH-1:0]    out_nx;
    logic                     cur_dir_nx;
    logic                     tc_nx;
    logic                     bound_err_nx;
    logic [EVT_CNT_WIDTH-1:0] evt_cnt_nx;

    logic [SUM_W-1:0] step_ext;
    logic [SUM_W-1:0] upper_ext;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] diff;
    logic             is_bounce;
    logic             eff_dir;
    logic             out_of_range;
    logic             up_over;
    logic             up_reach;
    logic             dn_under;
    logic             dn_reach;

    // Extra MSB keeps carry/borrow visible so a large step never aliases back in range.
    always_comb begin
        step_ext     = SUM_W'(step);
        upper_ext    = SUM_W'(upper_bound);
        sum          = {1'b0, out} + step_ext;
        diff         = {1'b0, out} - step_ext;
        is_bounce    = (mode == MODE_BOUNCE);
        eff_dir      = is_bounce ? cur_dir : dir;
        out_of_range = (out < lower_bound) || (out > upper_bound);
        up_over      = (sum > upper_ext);
        up_reach     = (sum >= upper_ext);
        dn_under     = diff[DATA_WIDTH] || (diff[DATA_WIDTH-1:0] < lower_bound);
        dn_reach     = diff[DATA_WIDTH] || (diff[DATA_WIDTH-1:0] <= lower_bound);
    end

    // Next-state: load > bound error hold > enable > hold.
    always_comb begin
        out_nx       = out;
        cur_dir_nx   = cur_dir;
        tc_nx        = 1'b0;
        evt_cnt_nx   = evt_cnt;
        bound_err_nx = (lower_bound > upper_bound);

        if (load) begin
            out_nx     = load_value;
            cur_dir_nx = dir;
            evt_cnt_nx = '0;
        end else if (!bound_err && en) begin
            if (!is_bounce) begin
                cur_dir_nx = dir;
            end
            if (out_of_range) begin
                out_nx = eff_dir ? upper_bound : lower_bound;
            end else if (step != '0) begin
                if (!eff_dir) begin
                    case (mode)
                        MODE_SAT: begin
                            if (up_reach) begin
                                out_nx = upper_bound;
                                tc_nx  = (out != upper_bound);
                            end else begin
                                out_nx = sum[DATA_WIDTH-1:0];
                            end
                        end
                        MODE_BOUNCE: begin
                            if (up_reach) begin
                                out_nx     = upper_bound;
                                cur_dir_nx = 1'b1;
                                tc_nx      = 1'b1;
                            end else begin
                                out_nx = sum[DATA_WIDTH-1:0];
                            end
                        end
                        default: begin
                            if (up_over) begin
                                out_nx = lower_bound;
                                tc_nx  = 1'b1;
                            end else begin
                                out_nx = sum[DATA_WIDTH-1:0];
                            end
                        end
                    endcase
                end else begin
                    case (mode)
                        MODE_SAT: begin
                            if (dn_reach) begin
                                out_nx = lower_bound;
                                tc_nx  = (out != lower_bound);
                            end else begin
                                out_nx = diff[DATA_WIDTH-1:0];
                            end
                        end
                        MODE_BOUNCE: begin
                            if (dn_reach) begin
                                out_nx     = lower_bound;
                                cur_dir_nx = 1'b0;
                                tc_nx      = 1'b1;
                            end else begin
                                out_nx = diff[DATA_WIDTH-1:0];
                            end
                        end
                        default: begin
                            if (dn_under) begin
                                out_nx = upper_bound;
                                tc_nx  = 1'b1;
                            end else begin
                                out_nx = diff[DATA_WIDTH-1:0];
                            end
                        end
                    endcase
                end
            end
        end

        if (tc_nx) begin
            evt_cnt_nx = evt_cnt + EVT_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= RESET_VALUE;
            cur_dir   <= 1'b0;
            tc        <= 1'b0;
            bound_err <= 1'b0;
            evt_cnt   <= '0;
        end else begin
            out       <= out_nx;
            cur_dir   <= cur_dir_nx;
            tc        <= tc_nx;
            bound_err <= bound_err_nx;
            evt_cnt   <= evt_cnt_nx;
        end
    end

endmodule

// File: tb/tb_bounded_step_counter.sv
// Directed bench for bounded_step_counter: wrap, saturate, bounce, overflow guard,
// out-of-range start, illegal bounds, load priority and asynchronous reset.
module tb_bounded_step_counter;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [31:0] load_value;
    logic [31:0] lower_bound;
    logic [31:0] upper_bound;
    logic [7:0]  step;
    logic        dir;
    logic [1:0]  mode;
    logic [31:0] out;
    logic        cur_dir;
    logic        tc;
    logic        bound_err;
    logic [15:0] evt_cnt;

    logic        b_en;
    logic        b_load;
    logic [7:0]  b_load_value;
    logic [7:0]  b_lower;
    logic [7:0]  b_upper;
    logic [7:0]  b_step;
    logic        b_dir;
    logic [1:0]  b_mode;
    logic [7:0]  b_out;
    logic        b_cur_dir;
    logic        b_tc;
    logic        b_bound_err;
    logic [15:0] b_evt_cnt;

    int n_total;
    int n_bad;
    int exp_evt;

    int wrap_out [6] = '{6, 9, 3, 6, 9, 3};
    int wrap_tc  [6] = '{0, 0, 1, 0, 0, 1};
    int sat_out  [5] = '{6, 2, 0, 0, 0};
    int sat_tc   [5] = '{0, 0, 1, 0, 0};
    int bnc_out  [7] = '{4, 6, 8, 6, 4, 2, 4};
    int bnc_tc   [7] = '{0, 0, 1, 0, 0, 1, 0};
    int bnc_dir  [7] = '{0, 0, 1, 1, 1, 0, 0};

    bounded_step_counter dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .load_value  (load_value),
        .lower_bound (lower_bound),
        .upper_bound (upper_bound),
        .step        (step),
        .dir         (dir),
        .mode        (mode),
        .out         (out),
        .cur_dir     (cur_dir),
        .tc          (tc),
        .bound_err   (bound_err),
        .evt_cnt     (evt_cnt)
    );

    bounded_step_counter #(
        .DATA_WIDTH    (8),
        .STEP_WIDTH    (8),
        .EVT_CNT_WIDTH (16)
    ) dut_narrow (
        .clk         (clk),
        .rst         (rst),
        .en          (b_en),
        .load        (b_load),
        .load_value  (b_load_value),
        .lower_bound (b_lower),
        .upper_bound (b_upper),
        .step        (b_step),
        .dir         (b_dir),
        .mode        (b_mode),
        .out         (b_out),
        .cur_dir     (b_cur_dir),
        .tc          (b_tc),
        .bound_err   (b_bound_err),
        .evt_cnt     (b_evt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst = 1'b1; en = 1'b0; load = 1'b0; load_value = '0;
        lower_bound = '0; upper_bound = '0; step = '0; dir = 1'b0; mode = 2'd0;
        b_en = 1'b0; b_load = 1'b0; b_load_value = '0; b_lower = '0; b_upper = '0;
        b_step = '0; b_dir = 1'b0; b_mode = 2'd0;

        repeat (2) tick();
        check("rst_out", 64'(out), 64'd0);
        check("rst_dir", 64'(cur_dir), 64'd0);
        check("rst_tc", 64'(tc), 64'd0);
        check("rst_berr", 64'(bound_err), 64'd0);
        check("rst_evt", 64'(evt_cnt), 64'd0);
        rst = 1'b0;
        tick();
        check("idle_out", 64'(out), 64'd0);

        // Overflow guard on the 8-bit instance: 100+200 must not alias to 44.
        b_lower = 8'd0; b_upper = 8'd255; b_step = 8'd200; b_mode = 2'd0;
        b_load = 1'b1; b_load_value = 8'd100;
        tick();
        check("ovf_load", 64'(b_out), 64'd100);
        b_load = 1'b0; b_en = 1'b1;
        tick();
        check("ovf_out", 64'(b_out), 64'd0);
        check("ovf_tc", 64'(b_tc), 64'd1);
        check("ovf_evt", 64'(b_evt_cnt), 64'd1);
        b_en = 1'b0;

        // Wrap up, with load and en asserted together on the first cycle.
        lower_bound = 32'd3; upper_bound = 32'd10; step = 8'd3; mode = 2'd0; dir = 1'b0;
        load = 1'b1; load_value = 32'd3; en = 1'b1;
        tick();
        check("wrap_load_out", 64'(out), 64'd3);
        check("wrap_load_tc", 64'(tc), 64'd0);
        load = 1'b0;
        exp_evt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (wrap_tc[i] != 0) exp_evt++;
            check("wrap_out", 64'(out), 64'(wrap_out[i]));
            check("wrap_tc", 64'(tc), 64'(wrap_tc[i]));
            check("wrap_evt", 64'(evt_cnt), 64'(exp_evt));
        end
        tick();
        tick();
        check("wrap_pre_out", 64'(out), 64'd9);
        load = 1'b1; load_value = 32'd7;
        tick();
        check("ldpri_out", 64'(out), 64'd7);
        check("ldpri_tc", 64'(tc), 64'd0);
        check("ldpri_evt", 64'(evt_cnt), 64'd0);

        // Saturate down.
        lower_bound = 32'd0; upper_bound = 32'd20; step = 8'd4; mode = 2'd1; dir = 1'b1;
        load_value = 32'd10;
        tick();
        check("sat_load_out", 64'(out), 64'd10);
        check("sat_load_dir", 64'(cur_dir), 64'd1);
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("sat_out", 64'(out), 64'(sat_out[i]));
            check("sat_tc", 64'(tc), 64'(sat_tc[i]));
        end
        check("sat_evt", 64'(evt_cnt), 64'd1);

        // Bounce; dir input flipped after load to show mode 2 ignores it.
        lower_bound = 32'd2; upper_bound = 32'd8; step = 8'd2; mode = 2'd2; dir = 1'b0;
        load = 1'b1; load_value = 32'd2;
        tick();
        check("bnc_load_out", 64'(out), 64'd2);
        load = 1'b0; dir = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("bnc_out", 64'(out), 64'(bnc_out[i]));
            check("bnc_tc", 64'(tc), 64'(bnc_tc[i]));
            check("bnc_dir", 64'(cur_dir), 64'(bnc_dir[i]));
        end
        check("bnc_evt", 64'(evt_cnt), 64'd2);

        // Out-of-range start, then illegal bounds and recovery.
        lower_bound = 32'd3; upper_bound = 32'd10; step = 8'd3; mode = 2'd0; dir = 1'b0;
        load = 1'b1; load_value = 32'd50;
        tick();
        check("oor_load", 64'(out), 64'd50);
        load = 1'b0;
        tick();
        check("oor_out", 64'(out), 64'd3);
        check("oor_tc", 64'(tc), 64'd0);
        lower_bound = 32'd12;
        tick();
        check("berr_set", 64'(bound_err), 64'd1);
        check("berr_first_out", 64'(out), 64'd12);
        tick();
        check("berr_hold1", 64'(out), 64'd12);
        tick();
        check("berr_hold2", 64'(out), 64'd12);
        check("berr_still", 64'(bound_err), 64'd1);
        lower_bound = 32'd3;
        tick();
        check("berr_clr", 64'(bound_err), 64'd0);
        check("berr_clr_out", 64'(out), 64'd12);
        tick();
        check("resume_out", 64'(out), 64'd3);
        check("resume_tc", 64'(tc), 64'd0);
        tick();
        check("resume_step", 64'(out), 64'd6);

        // Async reset between edges while outputs are non-zero.
        lower_bound = 32'd2; upper_bound = 32'd8; step = 8'd2; mode = 2'd2; dir = 1'b0;
        load = 1'b1; load_value = 32'd2;
        tick();
        load = 1'b0;
        repeat (3) tick();
        check("pre_rst_out", 64'(out), 64'd8);
        check("pre_rst_tc", 64'(tc), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out", 64'(out), 64'd0);
        check("arst_dir", 64'(cur_dir), 64'd0);
        check("arst_tc", 64'(tc), 64'd0);
        check("arst_evt", 64'(evt_cnt), 64'd0);
        tick();
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/bounded_step_counter.md
# bounded_step_counter

Parametrised successor to the team's bounded up-counter. Counts between run-time `lower_bound`/`upper_bound` with programmable step, up/down direction, and three boundary modes: wrap, saturate, bounce. Adds synchronous load, enable, a terminal-count event pulse and an event counter. Used as the general timebase/address generator in datapath and test blocks.

## Interface
- `DATA_WIDTH`, default 32: counter, bound and load width.
- `STEP_WIDTH`, default 8: width of `step`; must be ≤ `DATA_WIDTH`.
- `EVT_CNT_WIDTH`, default 16: width of `evt_cnt`.
- `RESET_VALUE`, default 0: value of `out` after reset.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  advance the counter this cycle.
- `load`  in  1  synchronous load of `load_value`; overrides `en`.
- `load_value`  in  DATA_WIDTH  value written on `load`.
- `lower_bound`  in  DATA_WIDTH  inclusive lower bound, unsigned.
- `upper_bound`  in  DATA_WIDTH  inclusive upper bound, unsigned.
- `step`  in  STEP_WIDTH  increment magnitude, unsigned.
- `dir`  in  1  requested direction: 0 up, 1 down.
- `mode`  in  2  0 wrap, 1 saturate, 2 bounce, 3 treated as wrap.
- `out`  out  DATA_WIDTH  current count.
- `cur_dir`  out  1  effective direction in use.
- `tc`  out  1  one-cycle boundary-event pulse.
- `bound_err`  out  1  high while `lower_bound > upper_bound`.
- `evt_cnt`  out  EVT_CNT_WIDTH  number of `tc` pulses, modulo 2^EVT_CNT_WIDTH.

## Operation
- Priority: `rst` > `load` > `bound_err` hold > `en` > hold.
- Reset (async assert, sync-safe deassert): `out`=RESET_VALUE, `cur_dir`=0, `tc`=0, `bound_err`=0, `evt_cnt`=0.
- Load: `out`←`load_value` (no range check), `cur_dir`←`dir`, `evt_cnt`←0, `tc`=0.
- `bound_err` is registered from `lower_bound > upper_bound` every cycle. While it is high, `en` is ignored and `out` holds. `load` still works.
- Modes 0/1: `cur_dir`←`dir` on every enabled cycle. Mode 2: `cur_dir` is internal state, set from `dir` on load, and toggles at bounds.
- Out-of-range start: on an enabled cycle where `out < lower_bound` or `out > upper_bound`, `out`←`lower_bound` if direction is up, else `upper_bound`. No `tc`.
- `step`=0: `out` holds and no events occur. The out-of-range correction still applies.
- Arithmetic uses a DATA_WIDTH+1-bit sum/difference, so carry or borrow never aliases.
- Up step, next = `out`+`step`:
  - next ≤ upper, and not bounce-landing on upper: `out`←next.
  - next > upper, wrap: `out`←`lower_bound` (no residual carried), `tc`.
  - saturate: `out`←`upper_bound`. `tc` only if `out` was not already `upper_bound`, including an exact landing. Once at upper, holds with no further `tc`.
  - bounce: next ≥ upper → `out`←`upper_bound`, `cur_dir`←1, `tc`.
- Down step, next = `out`−`step`: mirror image of up. Borrow or next < lower is an overflow.
  - wrap: `out`←`upper_bound`.
  - saturate: `out`←`lower_bound`.
  - bounce: next ≤ lower → `out`←`lower_bound`, `cur_dir`←0.
- Bounds changed mid-count: take effect on the next enabled cycle via the rules above.
- `evt_cnt` increments on each `tc`, wrapping to 0 after the maximum value.

## Timing
- All outputs are registered. `out`, `cur_dir`, `tc` and `evt_cnt` reflect the inputs sampled at the preceding rising edge: 1-cycle latency.
- `tc` is high in the same cycle that `out` shows the post-event value, for exactly one cycle per event.
- `bound_err` lags the bound inputs by 1 cycle. The first enabled cycle after the bounds become illegal may still step.
- Reset mid-count clears state immediately, without waiting for a clock edge.

## Test plan
- Wrap up:
  - Stimulus: bounds 3..10, step 3, mode 0, `dir` 0, load 3, `en` held.
  - Required: `out` 3,6,9,3,6,… with `tc` on each 9→3, and `evt_cnt` incrementing.
- Saturate down:
  - Stimulus: bounds 0..20, step 4, load 10, `dir` 1, mode 1.
  - Required: `out` 10,6,2,0,0,… with `tc` only on 2→0.
- Bounce:
  - Stimulus: bounds 2..8, step 2, load 2, mode 2.
  - Required: `out` 2,4,6,8,6,4,2,4. `tc` on arrival at 8 and at 2; `cur_dir` 1 then 0.
- Overflow guard:
  - Stimulus: DATA_WIDTH 8, bounds 0..255, step 200, load 100, mode 0.
  - Required: `out` 100→0 with `tc`; no alias to 44.
- Out-of-range and illegal bounds:
  - Load 50 with bounds 3..10, `en` → `out` 3, no `tc`.
  - Set lower 12, upper 10 → `bound_err`=1 one cycle later and `out` frozen. Restore the bounds → counting resumes.
- Async reset:
  - Assert `rst` between clock edges during counting → all outputs reset values immediately.
  - `load` + `en` in the same cycle → `load_value` wins and `tc`=0.
